dffram_512x32: RTL and testbench
================================

DFFRAM_512X32 -- requirements
Module: dffram_512x32

Interface
REQ-001 SHALL have parameter WSIZE, default 4, meaning bytes per word; data width = 8*WSIZE = 32.
REQ-002 SHALL have parameter BANKS, default 32, meaning 16-word banks; address width AWIDTH = clog2(BANKS)+4 = 9, depth 512.
REQ-003 SHALL have port CLK, input, 1 bit: single clock; all state changes on its rising edge.
REQ-004 SHALL have port RST, input, 1 bit: reset, synchronous and active-high.
REQ-005 SHALL have port EN0, input, 1 bit: port enable; gates both reads and writes.
REQ-006 SHALL have port WE0, input, 4 bits: byte write enables; bit i covers Di0[8i+7:8i].
REQ-007 SHALL have port A0, input, 9 bits: word address; A0[8:4] selects the bank, A0[3:0] the word in the bank.
REQ-008 SHALL have port Di0, input, 32 bits: write data.
REQ-009 SHALL have port Do0, output, 32 bits: registered read data.
REQ-010 SHALL have optional ports VPWR and VGND, inout, 1 bit each, present only when USE_POWER_PINS is defined, with no functional effect in RTL.

Function
REQ-011 SHALL store 512 words of 32 bits, all addresses 0x000-0x1FF valid, with no wrap or aliasing.
REQ-012 SHALL, at a rising CLK edge with RST=0, EN0=1, write Di0 byte i into mem[A0] byte i for each WE0[i]=1, leaving bytes with WE0[i]=0 unchanged.
REQ-013 SHALL, at a rising CLK edge with RST=0, EN0=1, load Do0 with mem[A0] (read latency 1 cycle), independent of WE0.
REQ-014 SHALL, on a simultaneous read and write to the same address, load Do0 with the pre-write contents (read-before-write).
REQ-015 SHALL, when EN0=0, ignore WE0, A0 and Di0, leave memory unchanged, and hold Do0 at its previous value.
REQ-016 SHALL treat WE0=4'b0000 with EN0=1 as a pure read.
REQ-017 SHALL leave memory contents undefined (X in simulation) after power-up until written.
REQ-018 SHALL implement the storage as per-bank 16x32 arrays with per-byte write gating, plus a bank decoder on A0[8:4] and a 32:1 output mux.

Reset
REQ-019 SHALL, at a rising CLK edge with RST=1, clear Do0 to 32'h0000_0000.
REQ-020 SHALL suppress writes during any cycle with RST=1, regardless of EN0 and WE0.
REQ-021 SHALL NOT clear memory contents on reset; data written before a reset SHALL be readable after it.
REQ-022 SHALL resume normal operation on the first rising edge after RST returns to 0.

Verification
REQ-023 Disabled write: with EN0=0, write 0x0/0x1/0x2 with WE0=1111, then read them -> memory unchanged and Do0 holds its prior value (0 after reset).
REQ-024 Full-word write/read, bank 0: EN0=1, write AA0055BB@0x0, AA0055CC@0x1, AA0055DD@0x2 -> read 0x0 returns AA0055BB one cycle after the address is presented.
REQ-025 Byte masks: write 00000033@0x2 with WE0=0001, 00003300@0x1 with 0010, 00330000@0x0 with 0100 -> reads return AA3355BB, AA0033CC, AA005533.
REQ-026 Bank coverage: repeat REQ-024/025 at 0x10-0x12 (same values), and with F0F055BB/CC/DD at 0xF0-0xF2 and 0x1F0-0x1F2 using masked AB000033/AB003300/AB330000 -> F033 55BB, F0F033CC, F0F05533; other banks undisturbed.
REQ-027 Same-address read/write: read 0x0 while writing 12345678 with WE0=1111 -> Do0 shows the old word, and the next read returns 12345678.
REQ-028 Reset: write 0xDEADBEEF to 0x1FF, assert RST for one cycle with EN0=1 and WE0=1111 at 0x1FF -> Do0=0 and the write is suppressed; a subsequent read of 0x1FF returns DEADBEEF.

Source files
------------

// File: rtl/dffram_512x32.sv
// dffram_512x32: banked single-port word RAM, byte write enables,
// registered read port, read-before-write on address collisions.
module dffram_512x32 #(
    parameter int WSIZE = 4,
    parameter int BANKS = 32,
    localparam int DWIDTH = 8 * WSIZE,
    localparam int AWIDTH = $clog2(BANKS) + 4
) (
`ifdef USE_POWER_PINS
    inout  wire                VPWR,
    inout  wire                VGND,
`endif
    input  logic               CLK,
    input  logic               RST,
    input  logic               EN0,
    input  logic [WSIZE-1:0]   WE0,
    input  logic [AWIDTH-1:0]  A0,
    input  logic [DWIDTH-1:0]  Di0,
    output logic [DWIDTH-1:0]  Do0
);

    localparam int BW = AWIDTH - 4;

    logic [BW-1:0]                  bank_sel;
    logic [3:0]                     word_sel;
    logic [BANKS-1:0]               bank_hit;
    logic [BANKS-1:0][WSIZE-1:0]    bank_be;
    logic [BANKS-1:0][DWIDTH-1:0]   bank_rd;
    logic [DWIDTH-1:0]              rd_word;
    logic [DWIDTH-1:0]              do_d;
    logic [DWIDTH-1:0]              do_q;

    assign bank_sel = A0[AWIDTH-1:4];
    assign word_sel = A0[3:0];

    // Bank decoder: only the addressed bank sees byte enables,
    // and nothing is written while disabled or in reset.
    always_comb begin
        bank_hit = '0;
        bank_be  = '0;
        if (EN0 && !RST) begin
            bank_hit[bank_sel] = 1'b1;
        end
        for (int b = 0; b < BANKS; b++) begin
            bank_be[b] = bank_hit[b] ? WE0 : '0;
        end
    end

    for (genvar b = 0; b < BANKS; b++) begin : g_bank
        // Storage has no reset; contents survive RST.
        logic [DWIDTH-1:0] mem_q [16];

        // Byte-gated write into this bank's 16-word array
        always_ff @(posedge CLK) begin
            for (int i = 0; i < WSIZE; i++) begin
                if (bank_be[b][i]) begin
                    mem_q[word_sel][8*i +: 8] <= Di0[8*i +: 8];
                end
            end
        end

        assign bank_rd[b] = mem_q[word_sel];
    end

    // Output mux across banks
    always_comb begin
        rd_word = bank_rd[bank_sel];
    end

    // Next read register value: clear, load, or hold
    always_comb begin
        do_d = do_q;
        if (RST) begin
            do_d = '0;
        end else if (EN0) begin
            do_d = rd_word;
        end
    end

    // Read data register; sees the array before this edge's write
    always_ff @(posedge CLK) begin
        do_q <= do_d;
    end

    assign Do0 = do_q;

endmodule

// File: tb/tb_dffram_512x32.sv
// tb_dffram_512x32: directed scenarios plus a randomized run
// checked against a word-array reference model.
module tb_dffram_512x32;

    logic        CLK = 1'b0;
    logic        RST = 1'b0;
    logic        EN0 = 1'b0;
    logic [3:0]  WE0 = 4'h0;
    logic [8:0]  A0  = 9'h0;
    logic [31:0] Di0 = 32'h0;
    logic [31:0] Do0;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] ref_mem   [512];
    bit   [3:0]  ref_known [512];
    logic [31:0] ref_do;
    bit          ref_do_ok;

    dffram_512x32 dut (
        .CLK (CLK),
        .RST (RST),
        .EN0 (EN0),
        .WE0 (WE0),
        .A0  (A0),
        .Di0 (Di0),
        .Do0 (Do0)
    );

    always #5 CLK = ~CLK;

    // One clock cycle: drive, clock, then advance the model.
    task automatic cyc(input bit rst, input bit en, input logic [3:0] we,
                       input logic [8:0] a, input logic [31:0] d);
        RST = rst;
        EN0 = en;
        WE0 = we;
        A0  = a;
        Di0 = d;
        @(posedge CLK);
        #1;
        if (rst) begin
            ref_do    = 32'h0;
            ref_do_ok = 1'b1;
        end else if (en) begin
            ref_do    = ref_mem[a];
            ref_do_ok = (ref_known[a] == 4'hF);
            for (int i = 0; i < 4; i++) begin
                if (we[i]) begin
                    ref_mem[a][8*i +: 8] = d[8*i +: 8];
                    ref_known[a][i]      = 1'b1;
                end
            end
        end
    endtask

    task automatic wr(input logic [8:0] a, input logic [3:0] we,
                      input logic [31:0] d);
        cyc(1'b0, 1'b1, we, a, d);
    endtask

    task automatic rd(input logic [8:0] a);
        cyc(1'b0, 1'b1, 4'h0, a, 32'h0);
    endtask

    task automatic test_reset;
        wr(9'h000, 4'hF, 32'h5A5A_0000);
        wr(9'h001, 4'hF, 32'h5A5A_0001);
        wr(9'h002, 4'hF, 32'h5A5A_0002);
        rd(9'h001);
        cyc(1'b1, 1'b0, 4'h0, 9'h0, 32'h0);
        n_checks++;
        if (Do0 !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_do0: got %h want 00000000", Do0);
        end
    endtask

    task automatic test_disabled_write;
        logic [31:0] exp_rd [3];
        exp_rd[0] = 32'h5A5A_0000;
        exp_rd[1] = 32'h5A5A_0001;
        exp_rd[2] = 32'h5A5A_0002;
        for (int i = 0; i < 3; i++) begin
            cyc(1'b0, 1'b0, 4'hF, 9'(i), 32'hFFFF_FFFF);
            n_checks++;
            if (Do0 !== 32'h0) begin
                n_fail++;
                $display("FAIL dis_hold[%0d]: got %h want 00000000", i, Do0);
            end
        end
        for (int i = 0; i < 3; i++) begin
            rd(9'(i));
            n_checks++;
            if (Do0 !== exp_rd[i]) begin
                n_fail++;
                $display("FAIL dis_mem[%0d]: got %h want %h", i, Do0, exp_rd[i]);
            end
        end
    endtask

    task automatic test_bank(input logic [8:0] base, input logic [15:0] hi,
                             input logic [15:0] mhi);
        logic [31:0] exp_rd [3];
        wr(base,     4'hF, {hi, 16'h55BB});
        wr(base + 1, 4'hF, {hi, 16'h55CC});
        wr(base + 2, 4'hF, {hi, 16'h55DD});
        rd(base);
        n_checks++;
        if (Do0 !== {hi, 16'h55BB}) begin
            n_fail++;
            $display("FAIL word_rd@%h: got %h want %h", base, Do0, {hi, 16'h55BB});
        end
        wr(base + 2, 4'b0001, {mhi, 16'h0033});
        wr(base + 1, 4'b0010, {mhi, 16'h3300});
        wr(base,     4'b0100, {mhi[15:8], 8'h33, 16'h0000});
        exp_rd[0] = {hi[15:8], 8'h33, 16'h55BB};
        exp_rd[1] = {hi, 16'h33CC};
        exp_rd[2] = {hi, 16'h5533};
        for (int i = 0; i < 3; i++) begin
            rd(base + 9'(i));
            n_checks++;
            if (Do0 !== exp_rd[i]) begin
                n_fail++;
                $display("FAIL mask_rd@%h: got %h want %h", base + 9'(i), Do0, exp_rd[i]);
            end
        end
    endtask

    task automatic test_bank_coverage;
        test_bank(9'h000, 16'hAA00, 16'h0000);
        test_bank(9'h010, 16'hAA00, 16'h0000);
        test_bank(9'h0F0, 16'hF0F0, 16'hAB00);
        test_bank(9'h1F0, 16'hF0F0, 16'hAB00);
        rd(9'h000);
        n_checks++;
        if (Do0 !== 32'hAA33_55BB) begin
            n_fail++;
            $display("FAIL undisturbed@000: got %h want aa3355bb", Do0);
        end
        rd(9'h011);
        n_checks++;
        if (Do0 !== 32'hAA00_33CC) begin
            n_fail++;
            $display("FAIL undisturbed@011: got %h want aa0033cc", Do0);
        end
        rd(9'h0F2);
        n_checks++;
        if (Do0 !== 32'hF0F0_5533) begin
            n_fail++;
            $display("FAIL undisturbed@0f2: got %h want f0f05533", Do0);
        end
    endtask

    task automatic test_same_addr;
        wr(9'h000, 4'hF, 32'h1234_5678);
        n_checks++;
        if (Do0 !== 32'hAA33_55BB) begin
            n_fail++;
            $display("FAIL rbw_old: got %h want aa3355bb", Do0);
        end
        rd(9'h000);
        n_checks++;
        if (Do0 !== 32'h1234_5678) begin
            n_fail++;
            $display("FAIL rbw_new: got %h want 12345678", Do0);
        end
    endtask

    task automatic test_reset_retention;
        wr(9'h1FF, 4'hF, 32'hDEAD_BEEF);
        rd(9'h1FF);
        cyc(1'b1, 1'b1, 4'hF, 9'h1FF, 32'h0BAD_F00D);
        n_checks++;
        if (Do0 !== 32'h0) begin
            n_fail++;
            $display("FAIL rst_clear: got %h want 00000000", Do0);
        end
        rd(9'h1FF);
        n_checks++;
        if (Do0 !== 32'hDEAD_BEEF) begin
            n_fail++;
            $display("FAIL rst_keep: got %h want deadbeef", Do0);
        end
    endtask

    task automatic test_random;
        logic [8:0] pool [16];
        for (int i = 0; i < 16; i++) begin
            pool[i] = 9'($urandom_range(0, 511));
            wr(pool[i], 4'hF, $urandom);
        end
        for (int n = 0; n < 400; n++) begin
            bit rst_r;
            bit en_r;
            rst_r = ($urandom_range(0, 19) == 0);
            en_r  = ($urandom_range(0, 3) != 0);
            cyc(rst_r, en_r, 4'($urandom), pool[$urandom_range(0, 15)], $urandom);
            if (ref_do_ok) begin
                n_checks++;
                if (Do0 !== ref_do) begin
                    n_fail++;
                    $display("FAIL rand[%0d]: got %h want %h", n, Do0, ref_do);
                end
            end
        end
    endtask

    initial begin
        ref_do    = 32'h0;
        ref_do_ok = 1'b0;
        for (int i = 0; i < 512; i++) begin
            ref_mem[i]   = 32'h0;
            ref_known[i] = 4'h0;
        end
        cyc(1'b1, 1'b0, 4'h0, 9'h0, 32'h0);
        test_reset;
        test_disabled_write;
        test_bank_coverage;
        test_same_addr;
        test_reset_retention;
        test_random;
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
